// File: rtl/datapath_pkg.sv
// datapath_pkg: shared constants for the Phase-2 CPU datapath.
//   DATA_W  - datapath width (32)
//   OP_*    - 5-bit ALU opcodes driven on CONTROL
//   word_t  - one datapath word
// Optional feature macro used by the ALU: DATAPATH_MULDIV_EN.
package datapath_pkg;

    localparam int unsigned DATA_W = 32;

    typedef logic [DATA_W-1:0] word_t;

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_AND  = 5'b00010;
    localparam logic [4:0] OP_OR   = 5'b00011;
    localparam logic [4:0] OP_SHR  = 5'b00100;
    localparam logic [4:0] OP_SHRA = 5'b00101;
    localparam logic [4:0] OP_SHL  = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_MUL  = 5'b01001;
    localparam logic [4:0] OP_NEG  = 5'b01010;
    localparam logic [4:0] OP_NOT  = 5'b01011;
    localparam logic [4:0] OP_DIV  = 5'b01100;

endpackage

// File: rtl/datapath_alu.sv
// alu: combinational ALU for the datapath. Computes A op B, or B+1 when inc_i is set.
// Ports:
//   a_i      - operand A (Y register)
//   b_i      - operand B (bus)
//   op_i     - opcode (OP_* from datapath_pkg)
//   inc_i    - PC increment override: result = B + 1
//   result_o - result, truncated to DATA_W bits
// Macro DATAPATH_MULDIV_EN: when defined MUL/DIV are built; otherwise they return 0.
module alu
    import datapath_pkg::*;
(
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [4:0]        op_i,
    input  logic              inc_i,
    output logic [DATA_W-1:0] result_o
);

    logic [4:0]          shamt;
    logic [2*DATA_W-1:0] rot_src;
    logic [2*DATA_W-1:0] ror_full;
    logic [2*DATA_W-1:0] rol_full;

    assign shamt   = b_i[4:0];
    // Rotates are shifts of A concatenated with itself; the wanted half is picked below.
    assign rot_src  = {a_i, a_i};
    assign ror_full = rot_src >> shamt;
    assign rol_full = rot_src << shamt;

    always_comb begin
        result_o = '0;
        if (inc_i) begin
            result_o = b_i + DATA_W'(1);
        end else begin
            case (op_i)
                OP_ADD:  result_o = a_i + b_i;
                OP_SUB:  result_o = a_i - b_i;
                OP_AND:  result_o = a_i & b_i;
                OP_OR:   result_o = a_i | b_i;
                OP_SHR:  result_o = a_i >> shamt;
                OP_SHRA: result_o = DATA_W'($signed(a_i) >>> shamt);
                OP_SHL:  result_o = a_i << shamt;
                OP_ROR:  result_o = ror_full[DATA_W-1:0];
                OP_ROL:  result_o = rol_full[2*DATA_W-1:DATA_W];
                OP_NEG:  result_o = DATA_W'(0) - a_i;
                OP_NOT:  result_o = ~a_i;
`ifdef DATAPATH_MULDIV_EN
                OP_MUL:  result_o = a_i * b_i;
                OP_DIV:  result_o = (b_i == '0) ? '0 : (a_i / b_i);
`endif
                default: result_o = '0;
            endcase
        end
    end

endmodule

// File: rtl/datapath.sv
// datapath: Phase-2 32-bit CPU datapath. A shared bus feeds PC, MAR, MDR, IR, Y, Z(ZLO),
// R2 and R5; the ALU computes Y op Bus into Z. An external controller drives one-hot
// out/in strobes each cycle.
// Ports:
//   Clock       - rising-edge clock
//   Clear       - asynchronous active-high reset of all registers
//   MData_In    - memory read data (MDR source when Read=1)
//   CONTROL     - ALU opcode; IncPC forces Bus+1
//   Read        - MDR input select (1: MData_In, 0: bus)
//   *_Out       - bus source selects, priority PC > MDR > ZLO > R2
//   *_In        - register load enables
//   BusMux_Out  - current bus value
// Macro DATAPATH_MULDIV_EN enables MUL/DIV in the ALU.
module datapath
    import datapath_pkg::*;
(
    input  logic              Clock,
    input  logic              Clear,
    input  logic [DATA_W-1:0] MData_In,
    input  logic [4:0]        CONTROL,
    input  logic              IncPC,
    input  logic              Read,
    input  logic              PC_Out,
    input  logic              MDR_Out,
    input  logic              ZLO_Out,
    input  logic              R2_Out,
    input  logic              PC_In,
    input  logic              MDR_In,
    input  logic              MAR_In,
    input  logic              IR_In,
    input  logic              Y_In,
    input  logic              ZLO_In,
    input  logic              R2_In,
    input  logic              R5_In,
    output logic [DATA_W-1:0] BusMux_Out
);

    word_t pc_q, mar_q, mdr_q, ir_q, y_q, z_q, r2_q, r5_q;
    word_t pc_d, mar_d, mdr_d, ir_d, y_d, z_d, r2_d, r5_d;
    word_t bus;
    word_t alu_result;

    always_comb begin
        bus = '0;
        if (PC_Out) begin
            bus = pc_q;
        end else if (MDR_Out) begin
            bus = mdr_q;
        end else if (ZLO_Out) begin
            bus = z_q;
        end else if (R2_Out) begin
            bus = r2_q;
        end
    end

    assign BusMux_Out = bus;

    alu u_alu (
        .a_i      (y_q),
        .b_i      (bus),
        .op_i     (CONTROL),
        .inc_i    (IncPC),
        .result_o (alu_result)
    );

    // Sources come only from _q registers, so a register may drive and load in one cycle.
    always_comb begin
        pc_d  = PC_In  ? bus : pc_q;
        mar_d = MAR_In ? bus : mar_q;
        mdr_d = MDR_In ? (Read ? MData_In : bus) : mdr_q;
        ir_d  = IR_In  ? bus : ir_q;
        y_d   = Y_In   ? bus : y_q;
        z_d   = ZLO_In ? alu_result : z_q;
        r2_d  = R2_In  ? bus : r2_q;
        r5_d  = R5_In  ? bus : r5_q;
    end

    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            pc_q  <= '0;
            mar_q <= '0;
            mdr_q <= '0;
            ir_q  <= '0;
            y_q   <= '0;
            z_q   <= '0;
            r2_q  <= '0;
            r5_q  <= '0;
        end else begin
            pc_q  <= pc_d;
            mar_q <= mar_d;
            mdr_q <= mdr_d;
            ir_q  <= ir_d;
            y_q   <= y_d;
            z_q   <= z_d;
            r2_q  <= r2_d;
            r5_q  <= r5_d;
        end
    end

endmodule

// File: tb/tb_datapath.sv
// tb_datapath: directed self-checking bench for datapath. Expected values are pushed to a
// scoreboard queue as each step is driven and popped when the DUT result is sampled.
module tb_datapath;
    import datapath_pkg::*;

    logic        Clock = 1'b0;
    logic        Clear;
    logic [31:0] MData_In;
    logic [4:0]  CONTROL;
    logic        IncPC, Read;
    logic        PC_Out, MDR_Out, ZLO_Out, R2_Out;
    logic        PC_In, MDR_In, MAR_In, IR_In, Y_In, ZLO_In, R2_In, R5_In;
    logic [31:0] BusMux_Out;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    datapath dut (
        .Clock      (Clock),
        .Clear      (Clear),
        .MData_In   (MData_In),
        .CONTROL    (CONTROL),
        .IncPC      (IncPC),
        .Read       (Read),
        .PC_Out     (PC_Out),
        .MDR_Out    (MDR_Out),
        .ZLO_Out    (ZLO_Out),
        .R2_Out     (R2_Out),
        .PC_In      (PC_In),
        .MDR_In     (MDR_In),
        .MAR_In     (MAR_In),
        .IR_In      (IR_In),
        .Y_In       (Y_In),
        .ZLO_In     (ZLO_In),
        .R2_In      (R2_In),
        .R5_In      (R5_In),
        .BusMux_Out (BusMux_Out)
    );

    always #5 Clock = ~Clock;

    task automatic ctl_zero();
        CONTROL = 5'b0; IncPC = 1'b0; Read = 1'b0;
        PC_Out = 1'b0; MDR_Out = 1'b0; ZLO_Out = 1'b0; R2_Out = 1'b0;
        PC_In = 1'b0; MDR_In = 1'b0; MAR_In = 1'b0; IR_In = 1'b0;
        Y_In = 1'b0; ZLO_In = 1'b0; R2_In = 1'b0; R5_In = 1'b0;
    endtask

    // Apply the current strobes on one rising edge, then clear them.
    task automatic tick();
        @(posedge Clock);
        #1;
        ctl_zero();
    endtask

    task automatic push(input string tag, input logic [31:0] exp);
        tag_q.push_back(tag);
        exp_q.push_back(exp);
    endtask

    task automatic check_pop(input logic [31:0] obs);
        string       tag;
        logic [31:0] exp;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %h required an expected entry", obs);
        end else begin
            tag = tag_q.pop_front();
            exp = exp_q.pop_front();
            assert (obs === exp) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", tag, obs, exp);
            end
        end
    endtask

    // Sample the bus shortly after the selects settle, away from any clock edge.
    task automatic bus_check(input string tag, input logic [31:0] exp);
        push(tag, exp);
        #1;
        check_pop(BusMux_Out);
    endtask

    task automatic mem_to_mdr(input logic [31:0] v);
        MData_In = v; Read = 1'b1; MDR_In = 1'b1;
        tick();
    endtask

    // Y <- v via MDR
    task automatic load_y(input logic [31:0] v);
        mem_to_mdr(v);
        MDR_Out = 1'b1; Y_In = 1'b1;
        tick();
    endtask

    // R2 <- v via MDR
    task automatic load_r2(input logic [31:0] v);
        mem_to_mdr(v);
        MDR_Out = 1'b1; R2_In = 1'b1;
        tick();
    endtask

    // Z <- Y op B, where B is R2 when use_r2 else 0; then read Z onto the bus.
    task automatic alu_op(input string tag, input logic [4:0] op, input logic inc,
                          input logic use_r2, input logic [31:0] exp);
        R2_Out = use_r2; CONTROL = op; IncPC = inc; ZLO_In = 1'b1;
        tick();
        ZLO_Out = 1'b1;
        bus_check(tag, exp);
        tick();
    endtask

    initial begin
        ctl_zero();
        MData_In = 32'h0;
        Clear    = 1'b1;

        // Reset state, read through every bus-visible register.
        #1;
        PC_Out = 1'b1;  bus_check("rst_pc", 32'h0);  PC_Out = 1'b0;
        MDR_Out = 1'b1; bus_check("rst_mdr", 32'h0); MDR_Out = 1'b0;
        ZLO_Out = 1'b1; bus_check("rst_z", 32'h0);   ZLO_Out = 1'b0;
        R2_Out = 1'b1;  bus_check("rst_r2", 32'h0);  R2_Out = 1'b0;
        @(negedge Clock);
        Clear = 1'b0;

        // Register load: MDR <- 8, then R2 <- MDR.
        mem_to_mdr(32'd8);
        MDR_Out = 1'b1; R2_In = 1'b1;
        bus_check("mdr_to_bus", 32'd8);
        tick();
        R2_Out = 1'b1;
        bus_check("r2_load", 32'd8);
        tick();

        // NEG execute T3-T5.
        R2_Out = 1'b1; Y_In = 1'b1;
        tick();
        CONTROL = OP_NEG; ZLO_In = 1'b1;
        tick();
        ZLO_Out = 1'b1; R5_In = 1'b1;
        bus_check("neg_t5_bus", 32'hFFFF_FFF8);
        tick();
        push("neg_r5", 32'hFFFF_FFF8);
        check_pop(dut.r5_q);

        // Fetch T0-T2 with PC = 0.
        PC_Out = 1'b1; MAR_In = 1'b1; IncPC = 1'b1; ZLO_In = 1'b1;
        tick();
        ZLO_Out = 1'b1;
        bus_check("fetch_t0_z", 32'd1);
        PC_In = 1'b1; Read = 1'b1; MDR_In = 1'b1; MData_In = 32'h8000_0000;
        tick();
        PC_Out = 1'b1;
        bus_check("fetch_t1_pc", 32'd1);
        PC_Out = 1'b0;
        MDR_Out = 1'b1; IR_In = 1'b1;
        tick();
        push("fetch_ir", 32'h8000_0000);
        check_pop(dut.ir_q);
        push("fetch_mar", 32'h0);
        check_pop(dut.mar_q);

        // Bus priority and idle bus.
        PC_Out = 1'b1; R2_Out = 1'b1;
        bus_check("prio_pc_r2", 32'd1);
        ctl_zero();
        bus_check("bus_idle", 32'h0);

        // Read without MDR_In leaves MDR unchanged.
        Read = 1'b1; MData_In = 32'hDEAD_BEEF;
        tick();
        MDR_Out = 1'b1;
        bus_check("read_no_load", 32'h8000_0000);
        ctl_zero();

        // ALU sweep with Y = 0xF0, B = 4.
        load_y(32'h0000_00F0);
        load_r2(32'd4);
        alu_op("alu_add",  OP_ADD,  1'b0, 1'b1, 32'h0000_00F4);
        alu_op("alu_sub",  OP_SUB,  1'b0, 1'b1, 32'h0000_00EC);
        alu_op("alu_and",  OP_AND,  1'b0, 1'b1, 32'h0000_0000);
        alu_op("alu_or",   OP_OR,   1'b0, 1'b1, 32'h0000_00F4);
        alu_op("alu_shr",  OP_SHR,  1'b0, 1'b1, 32'h0000_000F);
        alu_op("alu_shl",  OP_SHL,  1'b0, 1'b1, 32'h0000_0F00);
        alu_op("alu_ror",  OP_ROR,  1'b0, 1'b1, 32'h0000_000F);
        alu_op("alu_rol",  OP_ROL,  1'b0, 1'b1, 32'h0000_0F00);
        alu_op("alu_neg",  OP_NEG,  1'b0, 1'b1, 32'hFFFF_FF10);
        alu_op("alu_not",  OP_NOT,  1'b0, 1'b1, 32'hFFFF_FF0F);
        alu_op("alu_bad",  5'b11111, 1'b0, 1'b1, 32'h0);
        alu_op("alu_bad2", 5'b01101, 1'b0, 1'b1, 32'h0);
        alu_op("alu_inc",  OP_SUB,  1'b1, 1'b1, 32'd5);
`ifdef DATAPATH_MULDIV_EN
        alu_op("alu_div",  OP_DIV,  1'b0, 1'b1, 32'h0000_003C);
`else
        alu_op("alu_div",  OP_DIV,  1'b0, 1'b1, 32'h0);
`endif
        alu_op("alu_div0", OP_DIV,  1'b0, 1'b0, 32'h0);

        // Shifts and rotates of a value with the top bit set.
        load_y(32'h8000_0001);
        alu_op("alu_shra", OP_SHRA, 1'b0, 1'b1, 32'hF800_0000);
        alu_op("alu_shr_neg", OP_SHR, 1'b0, 1'b1, 32'h0800_0000);
        alu_op("alu_ror_wrap", OP_ROR, 1'b0, 1'b1, 32'h1800_0000);
        alu_op("alu_rol_wrap", OP_ROL, 1'b0, 1'b1, 32'h0000_0018);
        alu_op("alu_ror0", OP_ROR, 1'b0, 1'b0, 32'h8000_0001);

        // NOT of 0: Y loaded from an idle bus.
        Y_In = 1'b1;
        tick();
        alu_op("alu_not0", OP_NOT, 1'b0, 1'b0, 32'hFFFF_FFFF);

        // MUL 3 x 5.
        load_y(32'd3);
        load_r2(32'd5);
`ifdef DATAPATH_MULDIV_EN
        alu_op("alu_mul", OP_MUL, 1'b0, 1'b1, 32'd15);
`else
        alu_op("alu_mul", OP_MUL, 1'b0, 1'b1, 32'd0);
`endif

        // Reset mid-operation: Clear rises between edges with loads pending.
        push("pre_clear_r5", 32'hFFFF_FFF8);
        check_pop(dut.r5_q);
        MData_In = 32'h0000_1234; Read = 1'b1; MDR_In = 1'b1; Y_In = 1'b1; R5_In = 1'b1;
        #1;
        Clear = 1'b1;
        #1;
        push("clr_r5", 32'h0);  check_pop(dut.r5_q);
        push("clr_y", 32'h0);   check_pop(dut.y_q);
        push("clr_mar", 32'h0); check_pop(dut.mar_q);
        push("clr_ir", 32'h0);  check_pop(dut.ir_q);
        push("clr_r2", 32'h0);  check_pop(dut.r2_q);
        push("clr_z", 32'h0);   check_pop(dut.z_q);
        @(posedge Clock);
        #1;
        push("clr_mdr_held", 32'h0);
        check_pop(dut.mdr_q);
        ZLO_Out = 1'b1;
        bus_check("clr_bus_z", 32'h0);
        ctl_zero();
        PC_Out = 1'b1;
        bus_check("clr_bus_pc", 32'h0);
        ctl_zero();
        @(negedge Clock);
        Clear = 1'b0;

        // Loads work again once Clear drops.
        mem_to_mdr(32'h0000_1234);
        MDR_Out = 1'b1;
        bus_check("post_clear_mdr", 32'h0000_1234);
        ctl_zero();

        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL scoreboard_leftover: observed %0d entries expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/datapath.md
# datapath

Phase-2 32-bit CPU datapath: a shared bus feeds PC, MAR, MDR, IR, Y, Z and general registers R2/R5. A combinational ALU computes `Y op Bus` (or `Y` alone for unary ops) into the Z register. An external control unit (the testbench in Phase 2) sequences it through T-states by asserting one-hot out/in strobes each clock cycle.

## Interface
- Parameters: none (width 32 fixed via package constant `DATA_W`).
- `Clock` in 1: sole clock, rising-edge.
- `Clear` in 1: asynchronous, active-high reset of all registers.
- `MData_In` in 32: memory read data.
- `CONTROL` in 5: ALU opcode.
- `IncPC` in 1: forces ALU result = Bus + 1, overriding `CONTROL`.
- `Read` in 1: MDR input select (1 = `MData_In`, 0 = Bus).
- `PC_Out`, `MDR_Out`, `ZLO_Out`, `R2_Out` in 1 each: bus drive selects.
- `PC_In`, `MDR_In`, `MAR_In`, `IR_In`, `Y_In`, `ZLO_In`, `R2_In`, `R5_In` in 1 each: register load enables.
- `BusMux_Out` out 32: current bus value.

## Operation
- Bus is combinational, with priority PC > MDR > ZLO > R2. With no select asserted the bus is 0.
- Each register loads its input on a rising `Clock` when its enable is high. Otherwise it holds.
- PC, MAR, IR, Y, R2 and R5 load from the bus.
- MDR loads `Read ? MData_In : Bus`. `Read` without `MDR_In` has no effect.
- Z (ZLO, 32 bit) loads the ALU result when `ZLO_In` is high.
- ALU opcodes, with A = Y and B = Bus; results are truncated to 32 bits:
  - 00000 ADD: A+B. 00001 SUB: A−B. 00010 AND. 00011 OR.
  - 00100 SHR: logical A>>B[4:0]. 00101 SHRA: arithmetic. 00110 SHL.
  - 00111 ROR, 01000 ROL: by B[4:0].
  - 01001 MUL: low 32 bits of A*B. 01100 DIV: A/B unsigned, B=0 gives 0.
  - 01010 NEG: −A (two's complement). 01011 NOT: ~A.
  - All other codes give 0.
- `IncPC`=1 gives result = B+1 regardless of `CONTROL`.
- MAR and IR have no external output. R5 is write-only from the bus.

## Timing
- Reset: while `Clear`=1, every register (PC, MAR, MDR, IR, Y, Z, R2, R5) is 0, immediately and asynchronously. A load enabled on the same edge is lost.
- Register load latency is 1 clock. The new value is visible on the bus in the same cycle the register is selected.
- ALU and bus are zero-latency combinational paths.
- A register may be both bus source and destination in one cycle: it captures the old value, with no combinational loop.
- Fetch sequence:
  - T0: PC→MAR; PC+1 captured into Z.
  - T1: ZLO→PC; `MData_In`→MDR.
  - T2: MDR→IR.
- NEG execute:
  - T3: R2→Y.
  - T4: `CONTROL`=01010 with `ZLO_In`.
  - T5: ZLO→R5.

## Configuration
- `DATAPATH_MULDIV_EN` defined: MUL and DIV are implemented.
- Not defined: opcodes 01001 and 01100 give result 0, and no multiplier or divider is synthesised.

## Structure
- `datapath_pkg`: `DATA_W`=32 and the opcode localparams (`OP_ADD` … `OP_DIV`, `OP_NEG`=5'b01010).
- One sub-module `alu`: inputs A, B, op and inc; output result (combinational).
- Registers, bus mux and MDR mux live in the `datapath` top level.

## Test plan
- Register load: `MData_In`=8, `Read`+`MDR_In` → MDR=8. Then `MDR_Out`+`R2_In` → bus=8, R2=8.
- NEG: R2=8, do T3–T5 → `BusMux_Out`=0xFFFFFFF8 in T5, and R5 holds 0xFFFFFFF8.
- Fetch: PC=0, T0–T2 with `MData_In`=0x80000000 → Z=1 after T0, PC=1 after T1, IR=0x80000000.
- Bus priority: `PC_Out` and `R2_Out` together → bus = PC. No select → bus = 0.
- ALU sweep: Y=0xF0, B=4 → ADD 0xF4, SUB 0xEC, SHR 0x0F, SHL 0xF00, ROR 0x0000000F. NOT of 0 → 0xFFFFFFFF. MUL 3×5 → 15 (macro on) or 0 (macro off).
- Reset mid-operation: assert `Clear` between edges while R5=0xFFFFFFF8 → all registers 0 immediately, and loads are ignored while `Clear`=1.
